// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared RSA datapath constants and FSM state encoding
package rsa_pkg;

  localparam int RSA_DATA_LENGTH = 1024;
  localparam int RSA_CNT_WIDTH   = 11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mont_step.sv
// rtl/mont_step.sv - one radix-2 Montgomery iteration: S' = (S + a_i*B [+ M]) / 2
module mont_step
  import rsa_pkg::*;
#(
  parameter int DATA_LENGTH = RSA_DATA_LENGTH
) (
  input  logic [DATA_LENGTH+1:0] s,
  input  logic                   a_bit,
  input  logic [DATA_LENGTH-1:0] b,
  input  logic [DATA_LENGTH-1:0] m,
  output logic [DATA_LENGTH+1:0] s_next
);

  localparam int TW = DATA_LENGTH + 3;

  // One extra bit above S so the sum of up to S + B + M never wraps before the shift.
  logic [TW-1:0] t_add;
  logic [TW-1:0] t_red;

  assign t_add  = {1'b0, s} + (a_bit ? {3'b000, b} : '0);
  assign t_red  = t_add + (t_add[0] ? {3'b000, m} : '0);
  assign s_next = (DATA_LENGTH + 2)'(t_red >> 1);

endmodule

// File: rtl/montgomery_mult_serial.sv
// rtl/montgomery_mult_serial.sv - bit-serial Montgomery multiplier, result = A*B*2^-N mod M
// Optional modulus check (even M or M <= 1 flags err) enabled by MONT_MOD_CHECK_EN.
module montgomery_mult_serial
  import rsa_pkg::*;
#(
  parameter int DATA_LENGTH = RSA_DATA_LENGTH,
  parameter int CNT_WIDTH   = RSA_CNT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] A,
  input  logic [DATA_LENGTH-1:0] B,
  input  logic [DATA_LENGTH-1:0] M,
  output logic [DATA_LENGTH-1:0] result,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int SW = DATA_LENGTH + 2;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_LENGTH - 1);

  state_t                 state;
  logic [DATA_LENGTH-1:0] a_reg;
  logic [DATA_LENGTH-1:0] b_reg;
  logic [DATA_LENGTH-1:0] m_reg;
  logic [SW-1:0]          s_reg;
  logic [SW-1:0]          s_next;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   s_ge_m;
  logic [DATA_LENGTH-1:0] s_sub;
  logic                   mod_bad;

  mont_step #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_step (
    .s      (s_reg),
    .a_bit  (a_reg[0]),
    .b      (b_reg),
    .m      (m_reg),
    .s_next (s_next)
  );

  // Low N bits of S - M are exact because the final value is below 2M.
  assign s_ge_m = s_reg >= {2'b00, m_reg};
  assign s_sub  = s_reg[DATA_LENGTH-1:0] - m_reg;

`ifdef MONT_MOD_CHECK_EN
  logic err_q;
  assign mod_bad = ~M[0] | (M <= DATA_LENGTH'(1));
  assign err     = err_q;
`else
  assign mod_bad = 1'b0;
  assign err     = 1'b0;
`endif

  // done/busy are registered one edge behind the state, so the done cycle
  // overlaps IDLE and a held start restarts immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      result <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      m_reg  <= '0;
      s_reg  <= '0;
      cnt    <= '0;
`ifdef MONT_MOD_CHECK_EN
      err_q  <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          busy <= 1'b0;
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            m_reg <= M;
            s_reg <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef MONT_MOD_CHECK_EN
            err_q <= mod_bad;
`endif
            if (mod_bad) begin
              result <= '0;
              state  <= DONE;
            end else begin
              state  <= ITER;
            end
          end
        end
        ITER: begin
          s_reg <= s_next;
          a_reg <= a_reg >> 1;
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= FINAL;
        end
        FINAL: begin
          result <= s_ge_m ? s_sub : s_reg[DATA_LENGTH-1:0];
          state  <= DONE;
        end
        DONE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/montgomery_mult_serial.md
Name: montgomery_mult_serial

Overview:
- Bit-serial radix-2 Montgomery modular multiplier: RESULT = A·B·2^(-DATA_LENGTH) mod M.
- Sits directly downstream of the r / r² constant generator.
- Its R_t output (r² mod n) is fed as B to map operands into the Montgomery domain.
- Also serves as the core multiply for the later modular-exponentiation loop.

Parameters:
- DATA_LENGTH, 1024, operand/modulus width N. Bench also runs with 8.
- CNT_WIDTH, 11, iteration counter width; must hold the value DATA_LENGTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- A  input  DATA_LENGTH  multiplicand; requirement A < M
- B  input  DATA_LENGTH  multiplier (e.g. R_t); requirement B < M
- M  input  DATA_LENGTH  modulus; odd, M > 1
- result  output  DATA_LENGTH  A·B·2^-N mod M; valid when done=1 and held until the next accepted start
- busy  output  1  high from the accepted start through the done cycle
- done  output  1  one-cycle completion pulse
- err  output  1  modulus-error flag (see Optional Feature); constant 0 without the feature

Behaviour:
- Reset: when rst_n=0 at a clock edge, all state clears: state=IDLE, result=0, busy=0, done=0, err=0, accumulator=0, counter=0.
  - Reset mid-operation aborts the calculation with no done pulse.
- States: IDLE → ITER → FINAL → DONE → IDLE.
- IDLE: on start=1, capture A, B, M into internal registers; S=0; cnt=0; busy=1; go to ITER.
  - Inputs may change after capture without effect.
- ITER: one cycle per bit of A, LSB first (i = cnt).
  - T = S + (a_i ? B : 0).
  - If T is odd, T = T + M.
  - S = T >> 1.
  - cnt increments; after cnt reaches DATA_LENGTH-1 is processed, go to FINAL.
  - S is DATA_LENGTH+2 bits wide; no truncation is permitted before the shift.
- FINAL: if S ≥ M then result = S − M, else result = S[DATA_LENGTH-1:0]; go to DONE.
- DONE: done=1 for exactly this cycle; busy=1; next state IDLE (busy=0).
- Latency: start sampled at edge k → done high in the cycle following edge k+DATA_LENGTH+2.
  - A new start is accepted at edge k+DATA_LENGTH+3 at the earliest.
- start while busy is ignored; no queuing.
- start held continuously gives back-to-back operations, one per DATA_LENGTH+3 cycles.
- A=0 or B=0 gives result 0.
- Inputs ≥ M: result is congruent mod M but is not guaranteed < M. This is the caller's responsibility.

Optional Feature:
- Macro MONT_MOD_CHECK_EN.
- Defined:
  - In IDLE on start, if M[0]=0 or M ≤ 1, skip ITER/FINAL and go directly to DONE.
  - result=0, err=1 for that done cycle.
  - err is cleared on the next accepted start.
- Undefined: no check is made; err is tied 0; an even M yields an undefined result.

Decomposition:
- Shared package rsa_pkg holds:
  - DATA_LENGTH default
  - state encodings IDLE/ITER/FINAL/DONE
  - counter width
- This package is reused by the constant generator and the exponentiator.
- One natural combinational sub-module: mont_step. It takes (S, a_i, B, M) and returns the next S, implementing one add/conditional-add/shift iteration. This isolates the wide adder for timing work.

Test Plan:
- DATA_LENGTH=8, M=239, A=1, B=50 (r² mod M) → result=17 (= 2^8 mod 239); done exactly 11 cycles after the start edge (N+3); busy high for those cycles.
- M=239, A=17, B=17 → 17; then A=17, B=1 → 1 (exit from Montgomery domain); back-to-back starts with start held high.
- M=239, A=238, B=238 → 225 (2^-8 mod 239); A=0, B=200 → 0; exercises the FINAL subtract and zero paths.
- start pulsed at cycle 3 of an ITER run → ignored; result and latency unchanged from the first request. rst_n=0 at cycle 5 → busy=0, no done, result=0; a new start then completes normally.
- DATA_LENGTH=1024 with M from the constant generator's modulus, A=1, B=R_t → result equals R_r from that generator; done after 1027 cycles.
- MONT_MOD_CHECK_EN defined, M=238 → done after 1 cycle, err=1, result=0; next start with M=239 → err=0.
